// File: rtl/ram_sweep_pkg.sv
// ram_sweep_pkg: shared types and helpers for the ram_sweep block.
//   state_e   : controller FSM states (SWEEP, IDLE)
//   lanes()   : number of byte lanes in a word of the given width
//   even_par(): even-parity bit for one byte
package ram_sweep_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    function automatic int unsigned lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Bit that makes the byte plus parity carry an even number of ones.
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_sweep_ctl.sv
// ram_sweep_ctl: sweep/idle controller for ram_sweep.
//   clk, reset      : clock, synchronous active-high reset
//   we, re, clr     : request inputs from the client
//   addr            : client word address
//   busy            : registered, high while a sweep is in progress
//   sweep_c         : this cycle writes INIT_VAL to wr_addr_c (all lanes)
//   wr_en_c/rd_en_c : accepted client write/read this cycle
//   wr_addr_c       : write address (sweep pointer or client address)
module ram_sweep_ctl
    import ram_sweep_pkg::*;
#(
    parameter int unsigned ADDR = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            re,
    input  logic            clr,
    input  logic [ADDR-1:0] addr,
    output logic            busy,
    output logic            sweep_c,
    output logic            wr_en_c,
    output logic            rd_en_c,
    output logic [ADDR-1:0] wr_addr_c
);

    localparam int unsigned DEPTH = 2 ** ADDR;
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [ADDR-1:0] ptr_q, ptr_d;
    logic            busy_q, busy_d;

    // Next-state, sweep pointer and request gating.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sweep_c   = 1'b0;
        wr_en_c   = 1'b0;
        rd_en_c   = 1'b0;
        wr_addr_c = addr;
        case (state_q)
            SWEEP: begin
                sweep_c   = 1'b1;
                wr_addr_c = ptr_q;
                ptr_d     = ptr_q + ADDR'(1);   // wraps to 0 after the last word
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    // clr wins over any same-cycle read or write
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else begin
                    wr_en_c = we;
                    rd_en_c = re;
                end
            end
        endcase
        // Client requests never land while reset is asserted.
        if (reset) begin
            wr_en_c = 1'b0;
            rd_en_c = 1'b0;
        end
        busy_d = (state_d == SWEEP);
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/ram_sweep.sv
// ram_sweep: single-port synchronous RAM with per-byte write enables,
// registered read with valid pulse, and a hardware clear sweep that writes
// INIT_VAL to every word after reset or on a clr pulse.
//   clk, reset : clock, synchronous active-high reset
//   we, re     : write / read request (ignored while busy)
//   addr       : word address
//   in, be     : write data and byte-lane enables
//   clr        : one-cycle pulse starts a sweep
//   out        : registered read data (holds when out_valid is low)
//   out_valid  : one-cycle pulse when out was updated
//   busy       : sweep in progress
// Optional RAM_SWEEP_PARITY_EN adds per-lane even parity with
//   par_inj (in)  : store inverted parity on written lanes
//   par_err (out) : pulses with out_valid on a parity mismatch
module ram_sweep
    import ram_sweep_pkg::*;
#(
    parameter int unsigned     DATA     = 8,
    parameter int unsigned     ADDR     = 4,
    parameter logic [DATA-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR-1:0]      addr,
    input  logic [DATA-1:0]      in,
    input  logic [DATA/8-1:0]    be,
    input  logic                 clr,
    output logic [DATA-1:0]      out,
    output logic                 out_valid,
    output logic                 busy
`ifdef RAM_SWEEP_PARITY_EN
    ,
    input  logic                 par_inj,
    output logic                 par_err
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR;
    localparam int unsigned LANES = lanes(DATA);

    logic            sweep_c, wr_en_c, rd_en_c;
    logic [ADDR-1:0] wr_addr_c;

    ram_sweep_ctl #(
        .ADDR (ADDR)
    ) u_ctl (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .re        (re),
        .clr       (clr),
        .addr      (addr),
        .busy      (busy),
        .sweep_c   (sweep_c),
        .wr_en_c   (wr_en_c),
        .rd_en_c   (rd_en_c),
        .wr_addr_c (wr_addr_c)
    );

    logic [DATA-1:0]  mem [DEPTH];
    logic [LANES-1:0] lane_we_c;
    logic [DATA-1:0]  wdata_c;

    // Byte-lane write merge: the sweep writes every lane, a client write only its enabled lanes.
    always_comb begin
        lane_we_c = '0;
        wdata_c   = in;
        if (sweep_c) begin
            lane_we_c = '1;
            wdata_c   = INIT_VAL;
        end else if (wr_en_c) begin
            lane_we_c = be;
        end
    end

    // Storage array; not reset, the sweep initialises it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we_c[i]) begin
                mem[wr_addr_c][8*i +: 8] <= wdata_c[8*i +: 8];
            end
        end
    end

    logic [DATA-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;

    // Read path: array read is sampled before this edge's write, giving read-first.
    always_comb begin
        out_d       = out_q;
        out_valid_d = rd_en_c;
        if (rd_en_c) begin
            out_d = mem[addr];
        end
    end

`ifdef RAM_SWEEP_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] rd_calc_c;
    logic             par_err_q, par_err_d;

    // Stored parity; par_inj flips it on client writes only.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we_c[i]) begin
                par_mem[wr_addr_c][i] <= even_par(wdata_c[8*i +: 8]) ^ (par_inj & ~sweep_c);
            end
        end
    end

    // Recompute parity of the word being read and compare with stored bits.
    always_comb begin
        rd_calc_c = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_calc_c[i] = even_par(mem[addr][8*i +: 8]);
        end
        par_err_d = rd_en_c & (|(rd_calc_c ^ par_mem[addr]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ram_sweep.sv
// tb_ram_sweep: directed, table-driven bench for ram_sweep (DATA=32, ADDR=4).
// Build with RAM_SWEEP_PARITY_EN defined to include the parity sequence.
module tb_ram_sweep;

    localparam int unsigned DATA = 32;
    localparam int unsigned ADDR = 4;
    localparam logic [31:0] INIT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset, we, re, clr;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [31:0] out;
    logic        out_valid, busy;
    logic        par_inj;
    logic        par_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sweep #(
        .DATA     (DATA),
        .ADDR     (ADDR),
        .INIT_VAL (INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .in        (din),
        .be        (be),
        .clr       (clr),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
`ifdef RAM_SWEEP_PARITY_EN
        ,
        .par_inj   (par_inj),
        .par_err   (par_err)
`endif
    );

`ifndef RAM_SWEEP_PARITY_EN
    assign par_err = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic        ev;
        logic [31:0] eo;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at the posedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; clr = 1'b0; addr = '0; din = '0; be = '0; par_inj = 1'b0;
    endtask

    // Counts cycles with busy=1, starting from the current sample; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            cyc();
        end
    endtask

    task automatic read_word(input logic [3:0] a, input logic [31:0] exp, input string name);
        re = 1'b1; addr = a;
        cyc();
        re = 1'b0;
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " data"}, out, exp);
    endtask

    int n;
    int stray;

    initial begin
        // we,re,addr,be,din -> expected out_valid, out
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'hF, 32'h0000_00AA, 1'b0, INIT};
        vecs[1]  = '{1'b1, 1'b0, 4'h1, 4'hF, 32'h0000_00BB, 1'b0, INIT};
        vecs[2]  = '{1'b1, 1'b0, 4'h2, 4'hF, 32'h0000_00CC, 1'b0, INIT};
        vecs[3]  = '{1'b1, 1'b0, 4'h3, 4'hF, 32'h0000_00DD, 1'b0, INIT};
        vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'h0, 32'h0,         1'b1, 32'h0000_00AA};
        vecs[5]  = '{1'b0, 1'b1, 4'h1, 4'h0, 32'h0,         1'b1, 32'h0000_00BB};
        vecs[6]  = '{1'b0, 1'b1, 4'h2, 4'h0, 32'h0,         1'b1, 32'h0000_00CC};
        vecs[7]  = '{1'b0, 1'b1, 4'h3, 4'h0, 32'h0,         1'b1, 32'h0000_00DD};
        vecs[8]  = '{1'b1, 1'b0, 4'h5, 4'hF, 32'h1122_3344, 1'b0, 32'h0000_00DD};
        vecs[9]  = '{1'b1, 1'b0, 4'h5, 4'h2, 32'h0000_FF00, 1'b0, 32'h0000_00DD};
        vecs[10] = '{1'b0, 1'b1, 4'h5, 4'h0, 32'h0,         1'b1, 32'h1122_FF44};
        vecs[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h1122_FF44};
        vecs[12] = '{1'b0, 1'b1, 4'h0, 4'h0, 32'h0,         1'b1, 32'h0000_00AA};
        vecs[13] = '{1'b1, 1'b1, 4'h2, 4'hF, 32'h0000_0055, 1'b1, 32'h0000_00CC};
        vecs[14] = '{1'b0, 1'b1, 4'h2, 4'h0, 32'h0,         1'b1, 32'h0000_0055};
        vecs[15] = '{1'b0, 1'b0, 4'h2, 4'h0, 32'h0,         1'b0, 32'h0000_0055};
        vecs[16] = '{1'b1, 1'b0, 4'h6, 4'h9, 32'hAABB_CCDD, 1'b0, 32'h0000_0055};
        vecs[17] = '{1'b0, 1'b1, 4'h6, 4'h0, 32'h0,         1'b1, 32'hAAAD_BEDD};

        // Power-up reset
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst out", out, 32'h0);
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        reset = 1'b0;
        count_busy(n);
        chk("init sweep busy cycles", 32'(n), 32'd16);

        for (int a = 0; a < 16; a++) begin
            read_word(4'(a), INIT, "init read");
        end

        // Table-driven IDLE traffic
        for (int i = 0; i < 18; i++) begin
            we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr;
            be = vecs[i].be; din = vecs[i].din;
            cyc();
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d out", i), out, vecs[i].eo);
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
        end
        idle_inputs();

        // clr with a same-cycle write and read: both dropped, sweep starts
        clr = 1'b1; we = 1'b1; re = 1'b1; addr = 4'h1; din = 32'h1234_5678; be = 4'hF;
        cyc();
        idle_inputs();
        chk("clr valid", 32'(out_valid), 32'd0);
        re = 1'b1; addr = 4'h2;
        stray = 0;
        n = 0;
        while (busy && n < 100) begin
            if (out_valid) stray++;
            n++;
            cyc();
        end
        re = 1'b0;
        chk("clr sweep busy cycles", 32'(n), 32'd16);
        chk("reads during sweep", 32'(stray), 32'd0);
        chk("valid at sweep end", 32'(out_valid), 32'd0);
        chk("out held through sweep", out, 32'hAAAD_BEDD);
        for (int a = 0; a < 16; a++) begin
            read_word(4'(a), INIT, "post-clr read");
        end

        // Reset at sweep cycle 7 restarts a full sweep
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        chk("busy mid sweep", 32'(busy), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        count_busy(n);
        chk("restart sweep busy cycles", 32'(n), 32'd16);

        // Reset in IDLE with a read request: read discarded, out cleared
        we = 1'b1; addr = 4'h4; din = 32'h0BAD_F00D; be = 4'hF;
        cyc();
        we = 1'b0;
        read_word(4'h4, 32'h0BAD_F00D, "pre-reset read");
        reset = 1'b1; re = 1'b1; addr = 4'h4;
        cyc();
        re = 1'b0;
        chk("idle rst valid", 32'(out_valid), 32'd0);
        chk("idle rst out", out, 32'h0);
        reset = 1'b0;
        count_busy(n);
        chk("idle rst busy cycles", 32'(n), 32'd16);
        read_word(4'h4, INIT, "swept after reset");

`ifdef RAM_SWEEP_PARITY_EN
        // Parity injection and recovery
        we = 1'b1; addr = 4'h3; din = 32'h0000_00A5; be = 4'hF; par_inj = 1'b1;
        cyc();
        idle_inputs();
        chk("par_err idle", 32'(par_err), 32'd0);
        read_word(4'h3, 32'h0000_00A5, "par inj read");
        chk("par_err injected", 32'(par_err), 32'd1);
        cyc();
        chk("par_err pulse", 32'(par_err), 32'd0);
        we = 1'b1; addr = 4'h3; din = 32'h0000_00A5; be = 4'hF; par_inj = 1'b0;
        cyc();
        idle_inputs();
        read_word(4'h3, 32'h0000_00A5, "par clean read");
        chk("par_err clean", 32'(par_err), 32'd0);
        read_word(4'h7, INIT, "par swept read");
        chk("par_err swept", 32'(par_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
